// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between I-cache and D-cache
// onto one registered main-memory command port.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_req;
  logic   d_req;
  logic   pick_i;
  logic   pick_d;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // round-robin pick: on a tie the client that did not win last goes
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    unique case (1'b1)
      (i_req && d_req): begin
        pick_d = ~last_d;
        pick_i = last_d;
      end
      (i_req && !d_req): pick_i = 1'b1;
      (!i_req && d_req): pick_d = 1'b1;
      default: ;
    endcase
  end

  // completion is routed to the owning client only, in the ready cycle
  always_comb begin
    i_mem_ready = (state == SERVE_I) && mem_ready;
    d_mem_ready = (state == SERVE_D) && mem_ready;
    i_mem_rdata = i_mem_ready ? mem_rdata : '0;
    d_mem_rdata = d_mem_ready ? mem_rdata : '0;
  end

  // grant/serve FSM with registered memory command
  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_i) begin
            state     <= SERVE_I;
            last_d    <= 1'b0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_mem_addr;
            mem_wdata <= '0;
          end else if (pick_d) begin
            state     <= SERVE_D;
            last_d    <= 1'b1;
            mem_read  <= ~d_mem_write;
            mem_write <= d_mem_write;
            mem_addr  <= d_mem_addr;
            mem_wdata <= d_mem_wdata;
          end
        end
        SERVE_I,
        SERVE_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // saturating completion counters for perf debug
  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      if (i_mem_ready && (i_grant_cnt != '1))
        i_grant_cnt <= i_grant_cnt + 1'b1;
      if (d_mem_ready && (d_grant_cnt != '1))
        d_grant_cnt <= d_grant_cnt + 1'b1;
    end
  end

endmodule
